// File: rtl/cdi_bus_pkg.sv
// Shared types and constants for the SCC68070 bus fabric.
package cdi_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2,
    DONE = 2'd3
  } bus_state_t;

  localparam int MAX_TARGETS = 8;
  localparam int WDOG_W      = 16;

  typedef logic [2:0] tgt_idx_t;

endpackage

// File: rtl/cdi_bus_irq_delay.sv
// Per-target cooldown counter that emits one delayed access pulse.
// Only compiled in when BUS_ACCESS_IRQ_EN is defined.
`ifdef BUS_ACCESS_IRQ_EN
module cdi_bus_irq_delay #(
  parameter int unsigned IRQ_DELAY = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic pulse
);

  logic [7:0] cnt;

  // A reload while counting restarts the countdown, so only the final one pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= 8'd0;
    else if (load)
      cnt <= 8'(IRQ_DELAY);
    else if (cnt != 8'd0)
      cnt <= cnt - 8'd1;
  end

  assign pulse = (cnt == 8'd1);

endmodule
`endif

// File: rtl/cdi_bus_fabric.sv
// Range-mapped address decoder, chip-select and registered ack/data mux for the SCC68070 bus.
// Optional delayed per-target access pulses are enabled with BUS_ACCESS_IRQ_EN.
module cdi_bus_fabric
  import cdi_bus_pkg::*;
#(
  parameter int                     N_TARGETS      = 4,
  parameter logic [8*N_TARGETS-1:0] TGT_LO         = {8'h00, 8'h30, 8'h31, 8'h32},
  parameter logic [8*N_TARGETS-1:0] TGT_HI         = {8'h27, 8'h30, 8'h31, 8'h32},
  parameter int unsigned            TIMEOUT_CYCLES = 255,
  parameter int unsigned            IRQ_DELAY      = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [23:1]             cpu_addr,
  input  logic                    cpu_as,
  input  logic                    cpu_uds,
  input  logic                    cpu_lds,
  input  logic                    cpu_write_strobe,
  output logic [15:0]             cpu_din,
  output logic                    cpu_bus_ack,
  output logic                    cpu_bus_err,
  output logic [N_TARGETS-1:0]    tgt_cs,
  input  logic [16*N_TARGETS-1:0] tgt_dout,
  input  logic [N_TARGETS-1:0]    tgt_ack,
  output logic [N_TARGETS-1:0]    access_irq,
  output logic [15:0]             timeout_count
);

  if (N_TARGETS < 1 || N_TARGETS > MAX_TARGETS) begin : g_bad_n
    $error("N_TARGETS must be 1..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be 1..65535");
  end
  if (IRQ_DELAY < 1 || IRQ_DELAY > 255) begin : g_bad_irq
    $error("IRQ_DELAY must be 1..255");
  end

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  bus_state_t        state, state_nxt;
  tgt_idx_t          sel, hit_idx;
  logic              hit, req, sel_ack, wdog_expired;
  logic              enter_wait, ack_nxt, err_nxt, tmo_nxt;
  logic [WDOG_W-1:0] watchdog;
  logic [7:0]        page;
  logic [MAX_TARGETS-1:0] ack_pad;
  logic [15:0]       dout_arr [MAX_TARGETS];
  logic              unused_addr;

  assign req         = cpu_as && (cpu_uds || cpu_lds);
  assign page        = cpu_addr[23:16];
  assign unused_addr = ^cpu_addr[15:1];

  // Pad target inputs to the full index range so a 3-bit select is always in bounds.
  for (genvar i = 0; i < MAX_TARGETS; i++) begin : g_pad
    if (i < N_TARGETS) begin : g_used
      assign dout_arr[i] = tgt_dout[16*i +: 16];
      assign ack_pad[i]  = tgt_ack[i];
    end else begin : g_empty
      assign dout_arr[i] = 16'h0000;
      assign ack_pad[i]  = 1'b0;
    end
  end

  // Target 0 sits in the leftmost byte of TGT_LO/TGT_HI; descending scan lets the lowest index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_TARGETS - 1; i >= 0; i--) begin
      if (page >= TGT_LO[8*(N_TARGETS-1-i) +: 8] && page <= TGT_HI[8*(N_TARGETS-1-i) +: 8]) begin
        hit     = 1'b1;
        hit_idx = tgt_idx_t'(i);
      end
    end
  end

  assign sel_ack      = ack_pad[sel];
  assign wdog_expired = (watchdog == WDOG_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    enter_wait = 1'b0;
    ack_nxt    = 1'b0;
    err_nxt    = 1'b0;
    tmo_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            state_nxt  = WAIT;
            enter_wait = 1'b1;
          end else begin
            state_nxt = ERR;
          end
        end
      end
      WAIT: begin
        // Strobe loss aborts silently; an ack beats a same-cycle timeout.
        if (!cpu_as) begin
          state_nxt = IDLE;
        end else if (sel_ack) begin
          ack_nxt   = 1'b1;
          state_nxt = DONE;
        end else if (wdog_expired) begin
          tmo_nxt   = 1'b1;
          state_nxt = ERR;
        end
      end
      ERR: begin
        err_nxt   = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        if (!cpu_as)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel           <= '0;
      watchdog      <= '0;
      cpu_bus_ack   <= 1'b0;
      cpu_bus_err   <= 1'b0;
      cpu_din       <= 16'h0000;
      timeout_count <= 16'h0000;
    end else begin
      cpu_bus_ack <= ack_nxt;
      cpu_bus_err <= err_nxt;
      if (enter_wait)
        sel <= hit_idx;
      if (state == WAIT)
        watchdog <= watchdog + 1'b1;
      else
        watchdog <= '0;
      if (ack_nxt && !cpu_write_strobe)
        cpu_din <= dout_arr[sel];
      if (tmo_nxt)
        timeout_count <= sat_inc16(timeout_count);
    end
  end

  always_comb begin
    tgt_cs = '0;
    if (state == WAIT) begin
      for (int i = 0; i < N_TARGETS; i++) begin
        if (sel == tgt_idx_t'(i))
          tgt_cs[i] = 1'b1;
      end
    end
  end

`ifdef BUS_ACCESS_IRQ_EN
  for (genvar i = 0; i < N_TARGETS; i++) begin : g_irq
    cdi_bus_irq_delay #(
      .IRQ_DELAY(IRQ_DELAY)
    ) u_irq_delay (
      .clk   (clk),
      .reset (reset),
      .load  (enter_wait && (hit_idx == tgt_idx_t'(i))),
      .pulse (access_irq[i])
    );
  end
`else
  assign access_irq = '0;
`endif

endmodule

// File: tb/tb_cdi_bus_fabric.sv
// Directed bench for cdi_bus_fabric with a response scoreboard (kind, cycle, read data).
module tb_cdi_bus_fabric;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:1] cpu_addr;
  logic        cpu_as, cpu_uds, cpu_lds, cpu_write_strobe;
  logic [15:0] cpu_din;
  logic        cpu_bus_ack, cpu_bus_err;
  logic [3:0]  tgt_cs;
  logic [63:0] tgt_dout;
  logic [3:0]  tgt_ack;
  logic [3:0]  access_irq;
  logic [15:0] timeout_count;

  cdi_bus_fabric dut (
    .clk              (clk),
    .reset            (reset),
    .cpu_addr         (cpu_addr),
    .cpu_as           (cpu_as),
    .cpu_uds          (cpu_uds),
    .cpu_lds          (cpu_lds),
    .cpu_write_strobe (cpu_write_strobe),
    .cpu_din          (cpu_din),
    .cpu_bus_ack      (cpu_bus_ack),
    .cpu_bus_err      (cpu_bus_err),
    .tgt_cs           (tgt_cs),
    .tgt_dout         (tgt_dout),
    .tgt_ack          (tgt_ack),
    .access_irq       (access_irq),
    .timeout_count    (timeout_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [15:0] din;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          irq_cyc[$];
  logic [3:0]  irq_bits[$];
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  int          failed = 0;
  logic [15:0] model_din;
  int          c0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic begin_acc(input logic [23:0] byte_addr, input logic wr);
    cpu_addr         = byte_addr[23:1];
    cpu_as           = 1'b1;
    cpu_uds          = 1'b1;
    cpu_lds          = 1'b1;
    cpu_write_strobe = wr;
  endtask

  task automatic end_acc();
    cpu_as           = 1'b0;
    cpu_uds          = 1'b0;
    cpu_lds          = 1'b0;
    cpu_write_strobe = 1'b0;
  endtask

  task automatic push_exp(input bit is_err, input logic [15:0] din, input int at);
    exp_t e;
    e.is_err = is_err;
    e.din    = din;
    e.cyc    = at;
    sb.push_back(e);
  endtask

  // Every ack/err pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && (cpu_bus_ack || cpu_bus_err)) begin
      check("ack_err_exclusive", 32'(cpu_bus_ack & cpu_bus_err), 0);
      check("resp_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("resp_kind_err", 32'(cpu_bus_err), 32'(e.is_err));
        check("resp_cycle", cyc, e.cyc);
        check("resp_din", 32'(cpu_din), 32'(e.din));
      end
    end
    if (access_irq != 4'b0000) begin
      irq_cyc.push_back(cyc);
      irq_bits.push_back(access_irq);
    end
  end

  initial begin
    reset = 1'b1;
    end_acc();
    cpu_addr  = '0;
    tgt_dout  = '0;
    tgt_ack   = '0;
    model_din = 16'h0000;

    step(2);
    @(negedge clk);
    check("rst_cpu_din", 32'(cpu_din), 0);
    check("rst_ack", 32'(cpu_bus_ack), 0);
    check("rst_err", 32'(cpu_bus_err), 0);
    check("rst_cs", 32'(tgt_cs), 0);
    check("rst_irq", 32'(access_irq), 0);
    check("rst_tmo_count", 32'(timeout_count), 0);
    step(1);
    reset = 1'b0;
    step(2);

    // Read target 1, ack 3 cycles after cs; non-selected acks in between.
    c0 = cyc;
    begin_acc(24'h300010, 1'b0);
    model_din = 16'hBEEF;
    push_exp(1'b0, model_din, c0 + 5);
    @(negedge clk);
    check("t1_cs_before", 32'(tgt_cs), 0);
    step(1);
    @(negedge clk);
    check("t1_cs", 32'(tgt_cs), 32'h2);
    step(1);
    tgt_ack = 4'b0101;
    step(1);
    tgt_ack = 4'b0000;
    step(1);
    tgt_dout = 64'h0000_0000_BEEF_0000;
    tgt_ack  = 4'b0010;
    step(1);
    tgt_ack = 4'b0000;
    @(negedge clk);
    check("t1_ack", 32'(cpu_bus_ack), 1);
    check("t1_din", 32'(cpu_din), 32'hBEEF);
    check("t1_cs_done", 32'(tgt_cs), 0);
    step(1);
    end_acc();
    step(2);

    // Unmapped page: err two cycles after req, no chip select, strobe held long.
    c0 = cyc;
    begin_acc(24'h600000, 1'b0);
    push_exp(1'b1, model_din, c0 + 2);
    step(1);
    @(negedge clk);
    check("unm_cs", 32'(tgt_cs), 0);
    step(1);
    @(negedge clk);
    check("unm_err", 32'(cpu_bus_err), 1);
    step(4);
    end_acc();
    step(2);

    // Write at upper edge of target 0, fastest ack; read data must not change.
    c0 = cyc;
    begin_acc(24'h27FFFE, 1'b1);
    push_exp(1'b0, model_din, c0 + 2);
    step(1);
    tgt_dout = 64'h0000_0000_0000_1234;
    tgt_ack  = 4'b0001;
    @(negedge clk);
    check("wr_cs", 32'(tgt_cs), 32'h1);
    step(1);
    tgt_ack = 4'b0000;
    step(1);
    end_acc();
    step(2);

    // Just above target 0 range is unmapped.
    c0 = cyc;
    begin_acc(24'h280000, 1'b0);
    push_exp(1'b1, model_din, c0 + 2);
    step(3);
    end_acc();
    step(2);

    // Target 2 never acks: timeout after 255 WAIT cycles.
    c0 = cyc;
    begin_acc(24'h310000, 1'b0);
    push_exp(1'b1, model_din, c0 + 257);
    step(1);
    @(negedge clk);
    check("tmo_cs", 32'(tgt_cs), 32'h4);
    step(255);
    @(negedge clk);
    check("tmo_cs_err", 32'(tgt_cs), 0);
    check("tmo_count_1", 32'(timeout_count), 1);
    step(2);
    end_acc();
    step(2);

    // Ack in the exact timeout cycle wins.
    c0 = cyc;
    begin_acc(24'h310000, 1'b0);
    model_din = 16'hCAFE;
    tgt_dout  = 64'h0000_CAFE_0000_0000;
    push_exp(1'b0, model_din, c0 + 256);
    step(255);
    tgt_ack = 4'b0100;
    step(1);
    tgt_ack = 4'b0000;
    @(negedge clk);
    check("race_no_err", 32'(cpu_bus_err), 0);
    check("race_count", 32'(timeout_count), 1);
    step(1);
    end_acc();
    step(2);

    // Strobe dropped in WAIT: silent abort.
    c0 = cyc;
    begin_acc(24'h310000, 1'b0);
    step(2);
    @(negedge clk);
    check("abort_cs_wait", 32'(tgt_cs), 32'h4);
    step(1);
    end_acc();
    step(1);
    @(negedge clk);
    check("abort_cs_idle", 32'(tgt_cs), 0);
    step(5);

    // Reset during WAIT on target 3.
    c0 = cyc;
    begin_acc(24'h320000, 1'b0);
    step(2);
    @(negedge clk);
    check("rw_cs", 32'(tgt_cs), 32'h8);
    step(1);
    reset = 1'b1;
    #1;
    check("rw_cs_rst", 32'(tgt_cs), 0);
    check("rw_ack_rst", 32'(cpu_bus_ack), 0);
    check("rw_err_rst", 32'(cpu_bus_err), 0);
    check("rw_din_rst", 32'(cpu_din), 0);
    check("rw_count_rst", 32'(timeout_count), 0);
    model_din = 16'h0000;
    end_acc();
    step(2);
    reset = 1'b0;
    step(1);
    c0 = cyc;
    begin_acc(24'h300000, 1'b0);
    model_din = 16'h5A5A;
    tgt_dout  = 64'h0000_0000_5A5A_0000;
    push_exp(1'b0, model_din, c0 + 2);
    step(1);
    tgt_ack = 4'b0010;
    @(negedge clk);
    check("post_rst_cs", 32'(tgt_cs), 32'h2);
    step(1);
    tgt_ack = 4'b0000;
    step(1);
    end_acc();
    step(30);

    // Delayed access pulse on target 2.
    irq_cyc.delete();
    irq_bits.delete();
    c0 = cyc;
    begin_acc(24'h310002, 1'b0);
    model_din = 16'h1111;
    tgt_dout  = 64'h0000_1111_0000_0000;
    push_exp(1'b0, model_din, c0 + 2);
    step(1);
    tgt_ack = 4'b0100;
    step(1);
    tgt_ack = 4'b0000;
    step(1);
    end_acc();
    step(25);
`ifdef BUS_ACCESS_IRQ_EN
    check("irq_pulses", irq_cyc.size(), 1);
    if (irq_cyc.size() == 1) begin
      check("irq_cycle", irq_cyc[0], c0 + 20);
      check("irq_bits", 32'(irq_bits[0]), 32'h4);
    end
`else
    check("irq_none", 32'(irq_cyc.size() + irq_bits.size()), 0);
`endif

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
